// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage with PC, fetch FSM and IF/ID register (optional IF_PERF_CNT_EN counters)
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    output logic [31:0] inst_id,
    output logic [31:0] pc_id,
    output logic        valid_id
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pcid_q, pcid_d;
    logic        valid_q, valid_d;
    logic        req_raw;
    logic        load_valid;
    logic [31:0] pc_plus4;
    logic [31:0] target;

    assign pc_plus4 = pc_q + 32'd4;
    assign target   = {redirect_pc[31:2], 2'b00};

    // Next-state, IF/ID load and fetch-request decode; redirect overrides stall in every state
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hold_d     = hold_q;
        inst_d     = inst_q;
        pcid_d     = pcid_q;
        valid_d    = valid_q;
        req_raw    = 1'b0;
        im_addr    = pc_q;
        load_valid = 1'b0;

        if (redirect) begin
            pc_d    = target;
            inst_d  = NOP_INST;
            valid_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    req_raw = 1'b1;
                    im_addr = target;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (im_rvalid) begin
                        // Response retires now, so the target can be fetched at once
                        req_raw = 1'b1;
                        im_addr = target;
                    end else begin
                        // Old request still in flight: wait for it and throw it away
                        state_d = S_DROP;
                    end
                end
                S_HOLD: begin
                    hold_d  = '0;
                    req_raw = 1'b1;
                    im_addr = target;
                    state_d = S_WAIT;
                end
                S_DROP: begin
                    // If the stale response lands this cycle nothing remains outstanding
                    if (im_rvalid) begin
                        req_raw = 1'b1;
                        im_addr = target;
                        state_d = S_WAIT;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    req_raw = 1'b1;
                    im_addr = pc_q;
                    inst_d  = NOP_INST;
                    valid_d = 1'b0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (im_rvalid) begin
                        if (stall) begin
                            hold_d  = im_rdata;
                            state_d = S_HOLD;
                        end else begin
                            inst_d     = im_rdata;
                            pcid_d     = pc_q;
                            valid_d    = 1'b1;
                            load_valid = 1'b1;
                            pc_d       = pc_plus4;
                            req_raw    = 1'b1;
                            im_addr    = pc_plus4;
                        end
                    end else if (!stall) begin
                        inst_d  = NOP_INST;
                        valid_d = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        inst_d     = hold_q;
                        pcid_d     = pc_q;
                        valid_d    = 1'b1;
                        load_valid = 1'b1;
                        pc_d       = pc_plus4;
                        req_raw    = 1'b1;
                        im_addr    = pc_plus4;
                        state_d    = S_WAIT;
                    end
                end
                S_DROP: begin
                    inst_d  = NOP_INST;
                    valid_d = 1'b0;
                    if (im_rvalid) begin
                        req_raw = 1'b1;
                        im_addr = pc_q;
                        state_d = S_WAIT;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // No request may escape while reset is held, even though S_IDLE requests combinationally
    assign im_req = req_raw & rst_n;

    // State, PC, hold buffer and IF/ID register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
            inst_q  <= NOP_INST;
            pcid_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            inst_q  <= inst_d;
            pcid_q  <= pcid_d;
            valid_q <= valid_d;
        end
    end

    assign inst_id  = inst_q;
    assign pc_id    = pcid_q;
    assign valid_id = valid_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Counter increments; both wrap naturally at 2^32
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'd0, load_valid};
        stall_cnt_d = stall_cnt_q + {31'd0, stall & ~redirect};
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    logic unused_load_valid;
    assign unused_load_valid = load_valid;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage with a latency-programmable memory and program-order scoreboard
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_rvalid = 1'b0;
    logic [31:0] im_rdata = '0;
    logic [31:0] inst_id;
    logic [31:0] pc_id;
    logic        valid_id;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    if_stage u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .im_rvalid   (im_rvalid),
        .im_rdata    (im_rdata),
        .inst_id     (inst_id),
        .pc_id       (pc_id),
        .valid_id    (valid_id)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    bit          mem_busy = 1'b0;
    logic [31:0] mem_addr = '0;
    int          mem_cnt = 0;
    int          lat = 1;
    logic [31:0] key = '0;
    logic [31:0] exp_pc = '0;
    logic [31:0] exp_req = '0;
    logic [31:0] m_fetch = '0;
    logic [31:0] m_stall = '0;
    logic        req_s = 1'b0;
    logic [31:0] addr_s = '0;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ key;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic st, input logic rd, input logic [31:0] tgt);
        logic [31:0] o_inst;
        logic [31:0] o_pc;
        logic        o_valid;
        @(negedge clk);
        stall       = st;
        redirect    = rd;
        redirect_pc = tgt;
        im_rvalid   = mem_busy && (mem_cnt == 0);
        im_rdata    = im_rvalid ? mdata(mem_addr) : $urandom;
        #1;
        req_s   = im_req;
        addr_s  = im_addr;
        o_inst  = inst_id;
        o_pc    = pc_id;
        o_valid = valid_id;
        if (rd) exp_req = tgt & ~32'h3;
        if (req_s) begin
            chk("one_outstanding", 32'(mem_busy && !im_rvalid), 32'd0);
            chk("im_addr_order", addr_s, exp_req);
            exp_req = exp_req + 32'd4;
        end
        @(posedge clk);
        #1;
        if (im_rvalid) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        if (req_s) begin
            mem_busy = 1'b1;
            mem_addr = addr_s;
            mem_cnt  = lat - 1;
        end
        if (st && !rd) m_stall = m_stall + 32'd1;
        if (rd) begin
            chk("redirect_bubble", 32'(valid_id), 32'd0);
            exp_pc = tgt & ~32'h3;
        end else if (st) begin
            chk("stall_inst", inst_id, o_inst);
            chk("stall_pc", pc_id, o_pc);
            chk("stall_valid", 32'(valid_id), 32'(o_valid));
        end else if (valid_id) begin
            chk("id_pc", pc_id, exp_pc);
            chk("id_inst", inst_id, mdata(exp_pc));
            exp_pc  = exp_pc + 32'd4;
            m_fetch = m_fetch + 32'd1;
        end
    endtask

    task automatic check_reset_values();
        chk("rst_valid", 32'(valid_id), 32'd0);
        chk("rst_inst", inst_id, 32'h0);
        chk("rst_pc_id", pc_id, 32'h0);
        chk("rst_im_req", 32'(im_req), 32'd0);
`ifdef IF_PERF_CNT_EN
        chk("rst_perf_fetch", perf_fetch_cnt, 32'd0);
        chk("rst_perf_stall", perf_stall_cnt, 32'd0);
`endif
    endtask

    initial begin
        #12;
        check_reset_values();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Streaming with a 1-cycle memory
        lat = 1;
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0);
        chk("stream_pc", pc_id, 32'h0C);
        chk("stream_valid", 32'(valid_id), 32'd1);

        // Stall across the 0x10 response
        cycle(1'b1, 1'b0, 32'h0);
        chk("stall_no_req", 32'(req_s), 32'd0);
        chk("stall_pc_id", pc_id, 32'h0C);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b0, 32'h0);
            chk("hold_no_req", 32'(req_s), 32'd0);
        end
        cycle(1'b0, 1'b0, 32'h0);
        chk("release_req", 32'(req_s), 32'd1);
        chk("release_addr", addr_s, 32'h14);
        chk("release_pc_id", pc_id, 32'h10);

        // Redirect while a 3-cycle fetch is outstanding
        lat = 3;
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h40);
        chk("drop_no_req", 32'(req_s), 32'd0);
        cycle(1'b0, 1'b0, 32'h0);
        chk("drop_wait_req", 32'(req_s), 32'd0);
        chk("drop_bubble", 32'(valid_id), 32'd0);
        cycle(1'b0, 1'b0, 32'h0);
        chk("drop_refetch_req", 32'(req_s), 32'd1);
        chk("drop_refetch_addr", addr_s, 32'h40);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);
        chk("target_pc_id", pc_id, 32'h40);
        chk("target_valid", 32'(valid_id), 32'd1);

        // Redirect and stall together with a response, unaligned target
        lat = 1;
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h103);
        chk("rs_req", 32'(req_s), 32'd1);
        chk("rs_addr", addr_s, 32'h100);
        chk("rs_bubble", 32'(valid_id), 32'd0);
        cycle(1'b0, 1'b0, 32'h0);
        chk("unaligned_pc_id", pc_id, 32'h100);

        // PC wrap at the top of the address space
        cycle(1'b0, 1'b1, 32'hFFFF_FFF8);
        chk("wrap_first", addr_s, 32'hFFFF_FFF8);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        chk("wrap_addr", addr_s, 32'h0);
        chk("wrap_pc_id", pc_id, 32'hFFFF_FFFC);
        lat = 3;
        cycle(1'b0, 1'b0, 32'h0);
        chk("wrap_zero_pc_id", pc_id, 32'h0);

        // Reset pulse mid-fetch; the late response lands in S_IDLE
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        rst_n   = 1'b1;
        exp_pc  = 32'h0;
        exp_req = 32'h0;
        m_fetch = '0;
        m_stall = '0;
        key     = 32'hC0DE_0000;
        lat     = 1;
        cycle(1'b0, 1'b0, 32'h0);
        chk("post_rst_req", 32'(req_s), 32'd1);
        chk("post_rst_addr", addr_s, 32'h0);
        chk("post_rst_bubble", 32'(valid_id), 32'd0);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);
        chk("script_fetches", m_fetch, 32'd5);
`ifdef IF_PERF_CNT_EN
        chk("perf_fetch_script", perf_fetch_cnt, 32'd5);
        chk("perf_stall_script", perf_stall_cnt, 32'd2);
`endif

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 600; i++) begin
            logic        st;
            logic        rd;
            logic [31:0] tgt;
            lat = int'($urandom_range(1, 3));
            st  = ($urandom_range(0, 9) < 3);
            rd  = ($urandom_range(0, 19) == 0);
            tgt = $urandom & 32'h0000_0FFF;
            cycle(st, rd, tgt);
        end
        chk("progress", 32'(m_fetch >= 32'd60), 32'd1);
`ifdef IF_PERF_CNT_EN
        chk("perf_fetch_final", perf_fetch_cnt, m_fetch);
        chk("perf_stall_final", perf_stall_cnt, m_stall);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
